// File: rtl/sram_arbiter.sv
// Two-port arbiter for a 16-bit asynchronous SRAM: fixed SETUP/ACCESS/HOLD sequence, registered pins.
// Round-robin by default; define SRAM_ARB_FIXED_PRIO_EN for fixed priority with port A winning ties.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [1:0]        a_be,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [1:0]        b_be,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  output logic              busy,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Data
);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              gnt_b, gnt_b_d, wr, wr_d, drive, drive_d;
  logic [DATA_W-1:0] wdata, wdata_d;
  logic [ADDR_W-1:0] addr_d;
  logic              ce_d, ub_d, lb_d, oe_d, we_d;
  logic              a_ack_d, b_ack_d, capture;
  logic              grant, pick_b;
  logic [1:0]        be_sel;

  assign grant  = (state == IDLE) & (a_req | b_req);
  assign be_sel = pick_b ? b_be : a_be;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign pick_b = ~a_req;
`else
  // last_b remembers the previous winner so a tie goes to the other port
  logic last_b;
  assign pick_b = b_req & (~a_req | ~last_b);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)     last_b <= 1'b1;
    else if (grant) last_b <= pick_b;
  end
`endif

  // Next-state and next-pin values; every pin is registered below
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gnt_b_d = gnt_b;
    wr_d    = wr;
    wdata_d = wdata;
    drive_d = drive;
    addr_d  = ADDR;
    ce_d    = CE;
    ub_d    = UB;
    lb_d    = LB;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          state_d = SETUP;
          gnt_b_d = pick_b;
          wr_d    = pick_b ? b_we    : a_we;
          wdata_d = pick_b ? b_wdata : a_wdata;
          addr_d  = pick_b ? b_addr  : a_addr;
          ce_d    = 1'b0;
          ub_d    = ~be_sel[1];
          lb_d    = ~be_sel[0];
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
        drive_d = wr;
        we_d    = ~wr;
        oe_d    = wr;
      end
      ACCESS: begin
        if (cnt == CNT_LAST) begin
          state_d = HOLD;
          capture = ~wr;
          a_ack_d = ~gnt_b;
          b_ack_d = gnt_b;
        end else begin
          cnt_d = cnt + CNT_W'(1);
          we_d  = ~wr;
          oe_d  = wr;
        end
      end
      HOLD: begin
        // write data stays on the bus through HOLD for hold time, released entering IDLE
        state_d = IDLE;
        ce_d    = 1'b1;
        ub_d    = 1'b1;
        lb_d    = 1'b1;
        drive_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt_b   <= 1'b0;
      wr      <= 1'b0;
      wdata   <= '0;
      drive   <= 1'b0;
      ADDR    <= '0;
      CE      <= 1'b1;
      UB      <= 1'b1;
      LB      <= 1'b1;
      OE      <= 1'b1;
      WE      <= 1'b1;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      gnt_b <= gnt_b_d;
      wr    <= wr_d;
      wdata <= wdata_d;
      drive <= drive_d;
      ADDR  <= addr_d;
      CE    <= ce_d;
      UB    <= ub_d;
      LB    <= lb_d;
      OE    <= oe_d;
      WE    <= we_d;
      a_ack <= a_ack_d;
      b_ack <= b_ack_d;
      if (capture && !gnt_b) a_rdata <= Data;
      if (capture &&  gnt_b) b_rdata <= Data;
    end
  end

  assign busy = (state != IDLE);
  assign Data = drive ? wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed and random two-port traffic checked against a
// transaction-level model (grant edge -> strobe windows, ack cycle, memory contents).
module tb_sram_arbiter;
  localparam int W = 2;

  typedef struct packed {
    logic        we;
    logic [19:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } txn_t;

  logic        Clk = 1'b0, Reset = 1'b0;
  logic        a_req, a_we, b_req, b_we, a_ack, b_ack, busy, CE, UB, LB, OE, WE;
  logic [19:0] a_addr, b_addr, ADDR;
  logic [1:0]  a_be, b_be;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
  wire  [15:0] Data;

  sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(20), .DATA_W(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack),
    .busy(busy), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR), .Data(Data)
  );

  initial forever #5 Clk = ~Clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Asynchronous SRAM: drives the full word on read, byte-lane writes while WE is low
  logic [15:0] mem [0:1048575];
  assign Data = (!CE && !OE && WE) ? mem[ADDR] : 16'hzzzz;
  always @(posedge Clk)
    if (!CE && !WE) begin
      if (!UB) mem[ADDR][15:8] <= Data[15:8];
      if (!LB) mem[ADDR][7:0]  <= Data[7:0];
    end

  int checks = 0, errors = 0;
  logic [15:0] ref_mem [logic [19:0]];
  logic [19:0] pool [8] = '{20'h00010, 20'h0FFFF, 20'h00000, 20'hFFFFF,
                            20'h12345, 20'h00001, 20'h80000, 20'h0ABCD};
  txn_t pq [2][$];
  txn_t fld [2], cur [2], g_txn;
  bit   req_v [2], dropped [2], infl [2], seen [2];
  int   gap [2], ack_cyc [2];
  logic [15:0] last_rd [2];
  bit   last_b, rnd_mode;
  int   e, next_free, g_edge;
  int   ack_port [$], ack_at [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(logic we, logic [19:0] addr, logic [1:0] be, logic [15:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.be = be; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk(1'($urandom_range(1)), pool[$urandom_range(7)], 2'($urandom_range(3)), 16'($urandom));
  endfunction

  task automatic drive_pins();
    a_req = req_v[0]; a_we = fld[0].we; a_addr = fld[0].addr; a_be = fld[0].be; a_wdata = fld[0].wdata;
    b_req = req_v[1]; b_we = fld[1].we; b_addr = fld[1].addr; b_be = fld[1].be; b_wdata = fld[1].wdata;
  endtask

  task automatic model_reset();
    last_b = 1'b1; next_free = 0; g_edge = -100;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 0; dropped[p] = 0; infl[p] = 0; seen[p] = 0; gap[p] = 0;
      ack_cyc[p] = -1; last_rd[p] = 16'h0; fld[p] = '0;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    model_reset();
    drive_pins();
    @(posedge Clk); e++;
    @(negedge Clk);
    chk("reset_pins", 64'({CE, UB, LB, OE, WE, busy, a_ack, b_ack}), 64'(8'b11111000));
    chk("reset_addr", 64'(ADDR), 64'(0));
    chk("reset_rdata", 64'({a_rdata, b_rdata}), 64'(0));
    Reset = 1'b1;
  endtask

  // One clock of the requesters plus the spec-level timing model
  task automatic one_cycle();
    int c;
    bit pb, act, acc;
    logic [7:0] exp;
    logic [15:0] tmp;
    @(posedge Clk); e++;
    if (e >= next_free && (a_req || b_req)) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      pb = !a_req;
`else
      pb = !a_req || (b_req && !last_b);
`endif
      last_b = pb;
      cur[pb] = fld[pb]; g_txn = fld[pb]; g_edge = e; infl[pb] = 1;
      ack_cyc[pb] = e + 2 + W;
      next_free = e + 3 + W;
      if (rnd_mode && $urandom_range(3) == 0) dropped[pb] = 1;
      if (rnd_mode && $urandom_range(3) == 0) fld[pb] = rnd_txn();
    end
    #1;
    for (int p = 0; p < 2; p++) begin
      if (seen[p]) begin
        void'(pq[p].pop_front());
        infl[p] = 0; dropped[p] = 0; seen[p] = 0;
        gap[p] = rnd_mode ? $urandom_range(2) : 0;
      end else if (gap[p] > 0) gap[p]--;
      if (infl[p]) req_v[p] = !dropped[p];
      else begin
        req_v[p] = (pq[p].size() > 0) && (gap[p] == 0);
        if (pq[p].size() > 0) fld[p] = pq[p][0];
      end
    end
    drive_pins();
    @(negedge Clk);
    c   = e + 1;
    act = (c >= g_edge + 1) && (c <= g_edge + 2 + W);
    acc = (c >= g_edge + 2) && (c <= g_edge + 1 + W);
    exp = {!act, act ? ~g_txn.be[1] : 1'b1, act ? ~g_txn.be[0] : 1'b1,
           !(acc && !g_txn.we), !(acc && g_txn.we), act, ack_cyc[0] == c, ack_cyc[1] == c};
    chk("pins", 64'({CE, UB, LB, OE, WE, busy, a_ack, b_ack}), 64'(exp));
    if (act) chk("addr", 64'(ADDR), 64'(g_txn.addr));
    for (int p = 0; p < 2; p++) begin
      if (ack_cyc[p] == c) begin
        seen[p] = 1;
        if (cur[p].we) begin
          tmp = ref_mem[cur[p].addr];
          if (cur[p].be[1]) tmp[15:8] = cur[p].wdata[15:8];
          if (cur[p].be[0]) tmp[7:0]  = cur[p].wdata[7:0];
          ref_mem[cur[p].addr] = tmp;
          chk("mem_write", 64'(mem[cur[p].addr]), 64'(tmp));
        end else last_rd[p] = ref_mem[cur[p].addr];
        chk(p == 0 ? "a_rdata" : "b_rdata", 64'(p == 0 ? a_rdata : b_rdata), 64'(last_rd[p]));
        ack_port.push_back(p);
        ack_at.push_back(c);
      end
    end
  endtask

  task automatic run_phase(input string tag, input int budget);
    int n = 0;
    while ((pq[0].size() > 0 || pq[1].size() > 0) && n < budget) begin
      one_cycle();
      n++;
    end
    chk(tag, 64'(pq[0].size() + pq[1].size()), 64'(0));
    repeat (2) one_cycle();
  endtask

  initial begin
    logic [15:0] v;
    int exp_p;
    e = 0; rnd_mode = 0;
    model_reset();
    drive_pins();
    foreach (pool[i]) begin
      v = 16'($urandom);
      mem[pool[i]] <= v;
      ref_mem[pool[i]] = v;
    end
    mem[20'h00010] <= 16'hBEEF; ref_mem[20'h00010] = 16'hBEEF;
    mem[20'h0FFFF] <= 16'h1234; ref_mem[20'h0FFFF] = 16'h1234;
    do_reset();

    // single read from A
    pq[0].push_back(mk(1'b0, 20'h00010, 2'b11, 16'h0));
    run_phase("p1_done", 40);
    chk("p1_rdata", 64'(a_rdata), 64'(16'hBEEF));

    // single low-byte write from B
    pq[1].push_back(mk(1'b1, 20'h0FFFF, 2'b01, 16'hAA55));
    run_phase("p2_done", 40);
    chk("p2_mem", 64'(mem[20'h0FFFF]), 64'(16'h1255));

    // back-to-back write then read on A
    pq[0].push_back(mk(1'b1, 20'h00000, 2'b11, 16'h0001));
    pq[0].push_back(mk(1'b0, 20'h00000, 2'b11, 16'h0));
    run_phase("p3_done", 60);
    chk("p3_rdata", 64'(a_rdata), 64'(16'h0001));
    chk("p3_spacing", 64'(ack_at[ack_at.size()-1] - ack_at[ack_at.size()-2]), 64'(3 + W));

    // contention straight after reset
    do_reset();
    ack_port.delete(); ack_at.delete();
    for (int i = 0; i < 4; i++) begin
      pq[0].push_back(mk(1'b0, pool[i], 2'b11, 16'h0));
      pq[1].push_back(mk(1'b0, pool[i+4], 2'b11, 16'h0));
    end
    run_phase("p4_done", 200);
    chk("p4_count", 64'(ack_port.size()), 64'(8));
    for (int i = 0; i < ack_port.size() && i < 8; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      exp_p = (i < 4) ? 0 : 1;
`else
      exp_p = i % 2;
`endif
      chk("p4_order", 64'(ack_port[i]), 64'(exp_p));
      if (i > 0) chk("p4_spacing", 64'(ack_at[i] - ack_at[i-1]), 64'(3 + W));
    end

    // random traffic with gaps, dropped reqs and fields changing mid-access
    rnd_mode = 1;
    for (int i = 0; i < 24; i++) begin
      pq[0].push_back(rnd_txn());
      pq[1].push_back(rnd_txn());
    end
    run_phase("p5_done", 3000);
    rnd_mode = 0;

    // reset during the ACCESS phase of a write
    a_req = 1; a_we = 1; a_addr = pool[3]; a_be = 2'b11; a_wdata = ~ref_mem[pool[3]];
    @(posedge Clk);
    @(posedge Clk); #1;
    chk("p6_we_low", 64'({CE, WE, OE}), 64'(3'b001));
    #1 Reset = 1'b0;
    #1 chk("p6_async", 64'({CE, UB, LB, OE, WE, busy, a_ack}), 64'(7'b1111100));
    a_req = 0;
    @(posedge Clk); @(posedge Clk); #1 Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("p6_after", 64'({busy, a_ack, b_ack, a_rdata}), 64'(0));
    end
    chk("p6_mem", 64'(mem[pool[3]]), 64'(ref_mem[pool[3]]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
